// File: rtl/pll_phase_pkg.sv
// Shared types for the EHXPLLL dynamic phase controller: FSM states and PHASESEL codes.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
package pll_phase_pkg;

    // Controller sequencing states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STEP_LO = 3'd2,
        STEP_HI = 3'd3,
        LOAD_LO = 3'd4,
        SETTLE  = 3'd5,
        DONE    = 3'd6
    } state_t;

    // EHXPLLL PHASESEL[1:0] encodings
    localparam logic [1:0] SEL_CLKOS  = 2'b00;
    localparam logic [1:0] SEL_CLKOS2 = 2'b01;
    localparam logic [1:0] SEL_CLKOS3 = 2'b10;
    localparam logic [1:0] SEL_CLKOP  = 2'b11;

    // Width of the shared phase timer: it only ever holds CYC-1 of the longest phase
    function automatic int tmr_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/pll_dynamic_phase_ctrl_if.sv
// Request/status channel between software-facing logic and the phase controller.
// Latency: n/a (wires only).
// Backpressure: req_valid held until req_ready; requests arriving while busy are dropped.
interface pll_dynamic_phase_ctrl_if #(
    parameter int CNT_W = 8
) ();

    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_sel;
    logic             req_dir;
    logic [CNT_W-1:0] req_count;
    logic             req_load;
    logic             done;
    logic             error;
    logic             busy;

    // Requesting side
    modport master (
        output req_valid, req_sel, req_dir, req_count, req_load,
        input  req_ready, done, error, busy
    );

    // Controller side
    modport slave (
        input  req_valid, req_sel, req_dir, req_count, req_load,
        output req_ready, done, error, busy
    );

endinterface

// File: rtl/pll_dynamic_phase_ctrl_sync.sv
// Two-flop synchroniser for the asynchronous PLL LOCK signal.
// Latency: 2 clock cycles from d to q.
// Backpressure: none; resets to 0 so the controller starts out treating the PLL as unlocked.
module sync_2ff (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the asynchronous input through two flops
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_dynamic_phase_ctrl.sv
// Sequences EHXPLLL PHASESTEP / PHASELOADREG pulses and tracks a signed phase offset per PLL output.
// Latency: done in cycle 1+SETUP_CYC+N*(PULSE_CYC+GAP_CYC)+SETTLE_CYC after accept (load: PULSE_CYC instead of N pulses).
// Backpressure: req_ready only in IDLE with lock present; no queueing, requests while busy are ignored.
module pll_dynamic_phase_ctrl
    import pll_phase_pkg::*;
#(
    parameter int SETUP_CYC  = 2,
    parameter int PULSE_CYC  = 4,
    parameter int GAP_CYC    = 4,
    parameter int SETTLE_CYC = 64,
    parameter int CNT_W      = 8,
    parameter int OFF_W      = 10
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  pll_locked,
    pll_dynamic_phase_ctrl_if.slave req,
    input  logic [1:0]            offset_sel,
    output logic [OFF_W-1:0]      offset_out,
    output logic [1:0]            pll_phasesel,
    output logic                  pll_phasedir,
    output logic                  pll_phasestep,
    output logic                  pll_loadreg
);

    localparam int TMR_W = tmr_width(SETUP_CYC, PULSE_CYC, GAP_CYC, SETTLE_CYC);

    // Timer reload values: the timer counts CYC-1 down to 0, so a phase lasts CYC cycles
    localparam logic [TMR_W-1:0] T_SETUP  = TMR_W'(SETUP_CYC - 1);
    localparam logic [TMR_W-1:0] T_PULSE  = TMR_W'(PULSE_CYC - 1);
    localparam logic [TMR_W-1:0] T_GAP    = TMR_W'(GAP_CYC - 1);
    localparam logic [TMR_W-1:0] T_SETTLE = TMR_W'(SETTLE_CYC - 1);

    state_t           state;
    state_t           state_nxt;
    logic [TMR_W-1:0] tmr;
    logic [TMR_W-1:0] tmr_nxt;
    logic [CNT_W-1:0] steps_left;
    logic             lat_load;
    logic             err_q;
    logic             locked_sync;
    logic [OFF_W-1:0] offset_acc [4];

    logic             accept;
    logic             tmr_zero;
    logic             lock_lost;
    logic             step_done;
    logic             load_done;

    sync_2ff u_lock_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (pll_locked),
        .q       (locked_sync)
    );

    assign accept   = (state == IDLE) && locked_sync && req.req_valid;
    assign tmr_zero = (tmr == '0);

    // DONE is already on its way back to IDLE, so a lock drop there is not an abort
    assign lock_lost = (state != IDLE) && (state != DONE) && !locked_sync;

    // A low pulse only counts if it reaches its rising edge with lock still present
    assign step_done = (state == STEP_LO) && tmr_zero && !lock_lost;
    assign load_done = (state == LOAD_LO) && tmr_zero && !lock_lost;

    assign req.req_ready = (state == IDLE) && locked_sync;
    assign req.busy      = (state != IDLE);
    assign req.done      = (state == DONE);
    assign req.error     = err_q;

    assign offset_out = offset_acc[offset_sel];

    // State and phase timer registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            tmr   <= '0;
        end else begin
            state <= state_nxt;
            tmr   <= tmr_nxt;
        end
    end

    // Next-state logic: each timed phase reloads the shared timer on entry
    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr_zero ? tmr : tmr - 1'b1;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SETUP;
                    tmr_nxt   = T_SETUP;
                end
            end
            SETUP: begin
                if (tmr_zero) begin
                    if (lat_load) begin
                        state_nxt = LOAD_LO;
                        tmr_nxt   = T_PULSE;
                    end else if (steps_left != '0) begin
                        state_nxt = STEP_LO;
                        tmr_nxt   = T_PULSE;
                    end else begin
                        state_nxt = SETTLE;
                        tmr_nxt   = T_SETTLE;
                    end
                end
            end
            STEP_LO: begin
                if (tmr_zero) begin
                    state_nxt = STEP_HI;
                    tmr_nxt   = T_GAP;
                end
            end
            STEP_HI: begin
                // steps_left was already decremented at the end of the low pulse
                if (tmr_zero) begin
                    if (steps_left == '0) begin
                        state_nxt = SETTLE;
                        tmr_nxt   = T_SETTLE;
                    end else begin
                        state_nxt = STEP_LO;
                        tmr_nxt   = T_PULSE;
                    end
                end
            end
            LOAD_LO: begin
                if (tmr_zero) begin
                    state_nxt = SETTLE;
                    tmr_nxt   = T_SETTLE;
                end
            end
            SETTLE: begin
                if (tmr_zero) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                tmr_nxt   = '0;
            end
        endcase
        if (lock_lost) begin
            state_nxt = DONE;
            tmr_nxt   = '0;
        end
    end

    // Latch the request; PHASESEL/PHASEDIR come straight from the latch and hold through IDLE
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pll_phasesel <= SEL_CLKOS;
            pll_phasedir <= 1'b1;
            lat_load     <= 1'b0;
            steps_left   <= '0;
        end else if (accept) begin
            pll_phasesel <= req.req_sel;
            pll_phasedir <= req.req_dir;
            lat_load     <= req.req_load;
            steps_left   <= req.req_count;
        end else if (step_done) begin
            steps_left   <= steps_left - 1'b1;
        end
    end

    // Pulse outputs registered from next state so the PLL pins never glitch
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pll_phasestep <= 1'b1;
            pll_loadreg   <= 1'b1;
        end else begin
            pll_phasestep <= (state_nxt != STEP_LO);
            pll_loadreg   <= (state_nxt != LOAD_LO);
        end
    end

    // Sticky lock-loss flag, cleared when the next request is taken
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if (lock_lost) begin
            err_q <= 1'b1;
        end
    end

    // Per-output offset: +/-1 per completed step (wrapping), cleared by a static reload
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                offset_acc[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (pll_phasesel == 2'(i)) begin
                    if (load_done) begin
                        offset_acc[i] <= '0;
                    end else if (step_done) begin
                        offset_acc[i] <= offset_acc[i] + (pll_phasedir ? OFF_W'(1) : {OFF_W{1'b1}});
                    end
                end
            end
        end
    end

endmodule
